// File: rtl/clkrst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and its width.
package clkrst_seq_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD = 2'd0,
    ST_REL  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;
endpackage

// File: rtl/clkrst_rst_sync.sv
// Reset synchronizer: asserts asynchronously with rst, releases SYNC_STAGES clk edges after rst falls.
module clkrst_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/clkrst_seq_ctrl.sv
// Reset sequencer: holds all block resets, then releases them bit 0 first at fixed steps,
// and re-runs the sequence on an accepted software reset request.
module clkrst_seq_ctrl
  import clkrst_seq_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               busy,
  output logic               seq_done,
  output logic [STATE_W-1:0] state_o
);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  if (HOLD_CYCLES > 2**CNT_W) begin : g_bad_hold
    $error("HOLD_CYCLES does not fit in CNT_W");
  end
  if (STEP_CYCLES > 2**CNT_W) begin : g_bad_step
    $error("STEP_CYCLES does not fit in CNT_W");
  end

  logic rst_sync;

  clkrst_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ack_q, ack_d;
  logic               busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ack_d     = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = ST_REL;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = NUM_OUT'(1);
        end
      end
      ST_REL: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d   = ST_DONE;
            rst_out_d = '1;
          end else begin
            idx_d     = idx_q + 1'b1;
            // release the next bit above the current index
            rst_out_d = rst_out_q | (NUM_OUT'(2) << idx_q);
          end
        end
      end
      ST_DONE: begin
        cnt_d     = '0;
        rst_out_d = '1;
        if (sw_rst_req) begin
          ack_d     = 1'b1;
          state_d   = ST_HOLD;
          idx_d     = '0;
          rst_out_d = '0;
        end
      end
      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        idx_d     = '0;
        rst_out_d = '0;
      end
    endcase
  end

  // rst clears asynchronously; rst_sync keeps everything parked until it releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else if (rst_sync) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ack_q     <= ack_d;
      busy_q    <= (state_d != ST_DONE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign rst_out_n  = rst_out_q;
  assign sw_rst_ack = ack_q;
  assign busy       = busy_q;
  assign seq_done   = done_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_clkrst_seq_ctrl.sv
// Bench for clkrst_seq_ctrl: default instance plus a NUM_OUT=1/HOLD=1/STEP=1 corner instance,
// checked every cycle against a time-offset model and at hand-computed points.
module tb_clkrst_seq_ctrl;
  localparam int H0 = 16, S0 = 8, N0 = 4;
  localparam int H1 = 1,  S1 = 1, N1 = 1;

  logic       clk = 1'b0, rst = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic       ack0, ack1, busy0, busy1, done0, done1;
  logic [3:0] rn0;
  logic [0:0] rn1;
  logic [1:0] st0, st1;
  int n_tests = 0, n_fail = 0;
  int cur = 0;

  always #5 clk = ~clk;

  clkrst_seq_ctrl u0 (
    .clk(clk), .rst(rst), .sw_rst_req(req0), .sw_rst_ack(ack0),
    .rst_out_n(rn0), .busy(busy0), .seq_done(done0), .state_o(st0)
  );

  clkrst_seq_ctrl #(.NUM_OUT(1), .HOLD_CYCLES(1), .STEP_CYCLES(1), .CNT_W(8), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .sw_rst_req(req1), .sw_rst_ack(ack1),
    .rst_out_n(rn1), .busy(busy1), .seq_done(done1), .state_o(st1)
  );

  // Model: t = cycles since T0 (-1 while the synchronizer still holds reset).
  int t0 = -1, s0 = 0, t1 = -1, s1 = 0;
  logic mack0 = 1'b0, mack1 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin t0 = -1; s0 = 0; mack0 = 1'b0; end
    else begin
      mack0 = 1'b0;
      if (t0 >= H0 + N0*S0 && req0) begin mack0 = 1'b1; t0 = 0; end
      else if (t0 >= 0) t0++;
      else begin s0++; if (s0 >= 2) t0 = 0; end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin t1 = -1; s1 = 0; mack1 = 1'b0; end
    else begin
      mack1 = 1'b0;
      if (t1 >= H1 + N1*S1 && req1) begin mack1 = 1'b1; t1 = 0; end
      else if (t1 >= 0) t1++;
      else begin s1++; if (s1 >= 2) t1 = 0; end
    end
  end

  function automatic logic [3:0] exp_rn(int t, int h, int s, int n);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (t >= h + k*s);
    return r;
  endfunction

  function automatic logic [1:0] exp_st(int t, int h, int s, int n);
    if (t < h)         return 2'd0;
    if (t < h + n*s)   return 2'd1;
    return 2'd2;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e0, e1;
    logic [1:0] es0, es1;
    e0  = exp_rn(t0, H0, S0, N0);
    es0 = exp_st(t0, H0, S0, N0);
    e1  = exp_rn(t1, H1, S1, N1);
    es1 = exp_st(t1, H1, S1, N1);
    n_tests++;
    if ({rn0, busy0, done0, st0, ack0} !== {e0, es0 != 2'd2, es0 == 2'd2, es0, mack0}) begin
      n_fail++;
      $display("FAIL model0 t=%0d: got rn=%b busy=%b done=%b st=%0d ack=%b, want rn=%b busy=%b done=%b st=%0d ack=%b",
               t0, rn0, busy0, done0, st0, ack0, e0, es0 != 2'd2, es0 == 2'd2, es0, mack0);
    end
    n_tests++;
    if ({rn1, busy1, done1, st1, ack1} !== {e1[0], es1 != 2'd2, es1 == 2'd2, es1, mack1}) begin
      n_fail++;
      $display("FAIL model1 t=%0d: got rn=%b busy=%b done=%b st=%0d ack=%b, want rn=%b busy=%b done=%b st=%0d ack=%b",
               t1, rn1, busy1, done1, st1, ack1, e1[0], es1 != 2'd2, es1 == 2'd2, es1, mack1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic to(input int off);
    repeat (off - cur) @(negedge clk);
    cur = off;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cur = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset rn0", 32'(rn0), 32'h0);
    chk("reset busy0", 32'(busy0), 32'h1);
    chk("reset done0", 32'(done0), 32'h0);
    chk("reset st0", 32'(st0), 32'h0);
    chk("reset ack0", 32'(ack0), 32'h0);
    release_rst();

    // power-on sequence, both instances
    chk("u1 T0 rn", 32'(rn1), 32'h0);
    to(1);  chk("u1 T0+1 rn", 32'(rn1), 32'h1); chk("u1 T0+1 st", 32'(st1), 32'h1);
    to(2);  chk("u1 T0+2 done", 32'(done1), 32'h1); chk("u1 T0+2 busy", 32'(busy1), 32'h0);
    to(15); chk("T0+15 rn", 32'(rn0), 32'h0);
    to(16); chk("T0+16 rn", 32'(rn0), 32'h1);
    to(24); chk("T0+24 rn", 32'(rn0), 32'h3);
    to(32); chk("T0+32 rn", 32'(rn0), 32'h7);
    to(40); chk("T0+40 rn", 32'(rn0), 32'hf);
    to(47); chk("T0+47 done", 32'(done0), 32'h0);
    to(48); chk("T0+48 done", 32'(done0), 32'h1); chk("T0+48 busy", 32'(busy0), 32'h0);

    // one-cycle software request in DONE
    req0 = 1'b1;
    to(49); chk("sw ack", 32'(ack0), 32'h1); chk("sw rn", 32'(rn0), 32'h0); chk("sw st", 32'(st0), 32'h0);
    req0 = 1'b0; cur = 0;
    to(1);  chk("sw ack drop", 32'(ack0), 32'h0);
    to(16); chk("sw T0+16 rn", 32'(rn0), 32'h1);

    // early request held from T0+20
    to(20); req0 = 1'b1;
    to(40); chk("early no ack", 32'(ack0), 32'h0); chk("early T0+40 rn", 32'(rn0), 32'hf);
    to(48); chk("early done", 32'(done0), 32'h1); chk("early ack0", 32'(ack0), 32'h0);
    to(49); chk("early ack", 32'(ack0), 32'h1); chk("early done drop", 32'(done0), 32'h0);
    chk("early rn", 32'(rn0), 32'h0);
    req0 = 1'b0; cur = 0;

    // rst in the middle of the release phase
    to(30); chk("mid T0+30 rn", 32'(rn0), 32'h3);
    #2 rst = 1'b1;
    #1 chk("mid async rn", 32'(rn0), 32'h0); chk("mid async busy", 32'(busy0), 32'h1);
    repeat (3) @(negedge clk);
    release_rst();
    chk("mid T0 st", 32'(st0), 32'h0);
    to(15); chk("mid T0+15 rn", 32'(rn0), 32'h0);
    to(16); chk("mid T0+16 rn", 32'(rn0), 32'h1);
    to(48); chk("mid done", 32'(done0), 32'h1);

    // software reset on the corner instance
    req1 = 1'b1;
    @(negedge clk); chk("u1 sw ack", 32'(ack1), 32'h1); chk("u1 sw rn", 32'(rn1), 32'h0);
    req1 = 1'b0;
    @(negedge clk); chk("u1 sw T0+1 rn", 32'(rn1), 32'h1);
    @(negedge clk); chk("u1 sw done", 32'(done1), 32'h1);

    // short rst glitch between edges
    @(posedge clk); #1 rst = 1'b1; #3 rst = 1'b0;
    @(negedge clk); chk("glitch rn", 32'(rn0), 32'h0); chk("glitch sync0", 32'(u0.rst_sync), 32'h1);
    @(negedge clk); chk("glitch sync1", 32'(u0.rst_sync), 32'h1);
    @(negedge clk); chk("glitch sync2", 32'(u0.rst_sync), 32'h0);
    cur = 0;
    to(16); chk("glitch T0+16 rn", 32'(rn0), 32'h1);
    to(48); chk("glitch done", 32'(done0), 32'h1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
